// File: rtl/instr_cache.sv
// Direct-mapped, read-only instruction cache. A hit returns the word in the same cycle.
// A miss stalls the cpu for 1 + memory latency + 1 cycles while one block is fetched.
module instr_cache #(
    parameter  int unsigned ADDR_WIDTH      = 10,
    parameter  int unsigned NUM_BLOCKS      = 8,
    parameter  int unsigned WORDS_PER_BLOCK = 4,
    localparam int unsigned OFFSET_BITS     = $clog2(WORDS_PER_BLOCK),
    localparam int unsigned INDEX_BITS      = $clog2(NUM_BLOCKS),
    localparam int unsigned BLK_BITS        = ADDR_WIDTH - 2 - OFFSET_BITS,
    localparam int unsigned TAG_BITS        = BLK_BITS - INDEX_BITS
) (
    input  logic                            CLK,
    input  logic                            RESET,
    input  logic [31:0]                     PC,
    output logic [31:0]                     INSTRUCTION,
    output logic                            BUSYWAIT,
    output logic                            MEM_READ,
    output logic [BLK_BITS-1:0]             MEM_ADDRESS,
    input  logic [32*WORDS_PER_BLOCK-1:0]   MEM_READDATA,
    input  logic                            MEM_BUSYWAIT
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_UPDATE} state_t;

    state_t                                 state_q, state_d;
    logic [BLK_BITS-1:0]                    blk_q, blk_d;
    logic [NUM_BLOCKS-1:0]                  valid_q;
    logic [TAG_BITS-1:0]                    tag_q  [NUM_BLOCKS];
    logic [WORDS_PER_BLOCK-1:0][31:0]       data_q [NUM_BLOCKS];
    logic [WORDS_PER_BLOCK-1:0][31:0]       buf_q;

    logic [OFFSET_BITS-1:0]                 pc_offset;
    logic [INDEX_BITS-1:0]                  pc_index;
    logic [TAG_BITS-1:0]                    pc_tag;
    logic [BLK_BITS-1:0]                    pc_blk;
    logic [INDEX_BITS-1:0]                  fill_index;
    logic                                   hit;
    logic                                   unused_pc_bits;

    assign pc_offset      = PC[2 +: OFFSET_BITS];
    assign pc_index       = PC[2 + OFFSET_BITS +: INDEX_BITS];
    assign pc_tag         = PC[2 + OFFSET_BITS + INDEX_BITS +: TAG_BITS];
    assign pc_blk         = PC[2 + OFFSET_BITS +: BLK_BITS];
    assign fill_index     = blk_q[INDEX_BITS-1:0];
    assign hit            = valid_q[pc_index] && (tag_q[pc_index] == pc_tag);
    assign unused_pc_bits = ^{PC[31:ADDR_WIDTH], PC[1:0]};

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= S_IDLE;
            blk_q   <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
            if (state_q == S_UPDATE) valid_q[fill_index] <= 1'b1;
        end
    end

    // Line storage needs no reset; an aborted refill leaves state_q out of S_UPDATE.
    always_ff @(posedge CLK) begin
        if (state_q == S_READ && !MEM_BUSYWAIT) buf_q <= MEM_READDATA;
        if (state_q == S_UPDATE) begin
            data_q[fill_index] <= buf_q;
            tag_q[fill_index]  <= blk_q[BLK_BITS-1 -: TAG_BITS];
        end
    end

    always_comb begin
        state_d = state_q;
        blk_d   = blk_q;
        case (state_q)
            S_IDLE: begin
                if (!hit) begin
                    blk_d   = pc_blk;
                    state_d = S_READ;
                end
            end
            S_READ:   if (!MEM_BUSYWAIT) state_d = S_UPDATE;
            S_UPDATE: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs are forced quiet while RESET is held, even though PC may miss.
    always_comb begin
        INSTRUCTION = '0;
        BUSYWAIT    = 1'b0;
        MEM_READ    = 1'b0;
        MEM_ADDRESS = '0;
        if (RESET) begin
            case (state_q)
                S_IDLE: begin
                    BUSYWAIT    = !hit;
                    INSTRUCTION = data_q[pc_index][pc_offset];
                end
                S_READ: begin
                    BUSYWAIT    = 1'b1;
                    MEM_READ    = 1'b1;
                    MEM_ADDRESS = blk_q;
                end
                S_UPDATE: BUSYWAIT = 1'b1;
                default:  BUSYWAIT = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_cache.sv
// Scoreboard bench for instr_cache: the driver queues the expected word, stall count and
// refill block addresses per fetch; a negedge monitor accumulates and compares on acceptance.
module tb_instr_cache;

    logic         CLK = 1'b0;
    logic         RESET = 1'b1;
    logic [31:0]  PC = '0;
    logic [31:0]  INSTRUCTION;
    logic         BUSYWAIT;
    logic         MEM_READ;
    logic [5:0]   MEM_ADDRESS;
    logic [127:0] MEM_READDATA;
    logic         MEM_BUSYWAIT;

    instr_cache #(.ADDR_WIDTH(10), .NUM_BLOCKS(8), .WORDS_PER_BLOCK(4)) dut (
        .CLK(CLK), .RESET(RESET), .PC(PC), .INSTRUCTION(INSTRUCTION), .BUSYWAIT(BUSYWAIT),
        .MEM_READ(MEM_READ), .MEM_ADDRESS(MEM_ADDRESS), .MEM_READDATA(MEM_READDATA),
        .MEM_BUSYWAIT(MEM_BUSYWAIT)
    );

    always #5 CLK = ~CLK;

    // Memory: stays busy for lat-1 cycles of MEM_READ; word w of block b = CAFE_0000 | b<<8 | w.
    int lat = 5;
    int mcnt = 0;
    always @(posedge CLK) mcnt <= MEM_READ ? mcnt + 1 : 0;
    assign MEM_BUSYWAIT = MEM_READ && (mcnt + 1 < lat);
    always_comb begin
        MEM_READDATA = '0;
        for (int w = 0; w < 4; w++)
            MEM_READDATA[32*w +: 32] = 32'hCAFE_0000 | (32'(MEM_ADDRESS) << 8) | 32'(w);
    end

    typedef struct {
        string       name;
        logic [31:0] instr;
        int          stalls;
        int          first_ma;
        int          last_ma;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passes = 0;
    logic req = 1'b0;
    logic done = 1'b0;
    int   st = 0;
    int   fma = -1;
    int   lma = -1;

    task automatic check(input string nm, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    always @(negedge CLK) begin
        if (req && !done) begin
            if (BUSYWAIT) begin
                st++;
                if (MEM_READ) begin
                    if (fma < 0) fma = int'(MEM_ADDRESS);
                    lma = int'(MEM_ADDRESS);
                end
            end else if (q.size() == 0) begin
                check("unexpected_accept", 1, 0);
                done = 1'b1;
            end else begin
                exp_t e;
                e = q.pop_front();
                check({e.name, "_instr"}, INSTRUCTION, e.instr);
                check({e.name, "_stalls"}, st, e.stalls);
                check({e.name, "_first_memaddr"}, fma, e.first_ma);
                check({e.name, "_last_memaddr"}, lma, e.last_ma);
                st = 0; fma = -1; lma = -1;
                done = 1'b1;
            end
        end
    end

    // Entered and left just after/at a posedge; also releases RESET together with the new PC.
    task automatic fetch(input string nm, input logic [31:0] pc, input logic [31:0] instr,
                         input int stalls, input int f_ma, input int l_ma,
                         input int sw_after = -1, input logic [31:0] sw_pc = '0);
        exp_t e;
        int   k;
        #1;
        e.name = nm; e.instr = instr; e.stalls = stalls; e.first_ma = f_ma; e.last_ma = l_ma;
        q.push_back(e);
        PC = pc;
        RESET = 1'b1;
        st = 0; fma = -1; lma = -1;
        done = 1'b0;
        req = 1'b1;
        k = 0;
        while (!done && k < 100) begin
            @(posedge CLK);
            k++;
            if (k == sw_after) begin
                #1 PC = sw_pc;
            end
        end
        if (!done) begin
            check({nm, "_timeout"}, 0, 1);
            q.delete();
            done = 1'b1;
        end
    endtask

    initial begin
        int k;
        #3 RESET = 1'b0;
        #4;
        check("rst_busywait", BUSYWAIT, 0);
        check("rst_mem_read", MEM_READ, 0);
        check("rst_mem_address", MEM_ADDRESS, 0);
        check("rst_instruction", INSTRUCTION, 0);
        @(posedge CLK);

        fetch("t1_cold_miss", 32'h000, 32'hCAFE_0000, 7, 0, 0);
        fetch("t2_hit_w1", 32'h004, 32'hCAFE_0001, 0, -1, -1);
        fetch("t2_hit_w2", 32'h008, 32'hCAFE_0002, 0, -1, -1);
        fetch("t2_hit_w3", 32'h00C, 32'hCAFE_0003, 0, -1, -1);
        fetch("t3_conflict", 32'h080, 32'hCAFE_0800, 7, 8, 8);
        fetch("t3_evicted", 32'h000, 32'hCAFE_0000, 7, 0, 0);

        lat = 0;
        fetch("t5_zero_lat", 32'h034, 32'hCAFE_0301, 3, 3, 3);
        fetch("t5_hit", 32'h038, 32'hCAFE_0302, 0, -1, -1);
        lat = 5;

        // Reset in the middle of a refill of line 1.
        #1;
        req = 1'b0;
        PC = 32'h010;
        k = 0;
        while (!MEM_READ && k < 20) begin
            @(posedge CLK);
            #1;
            k++;
        end
        check("t4_mem_read_seen", MEM_READ, 1);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        check("t4_rst_mem_read", MEM_READ, 0);
        check("t4_rst_busywait", BUSYWAIT, 0);
        check("t4_rst_mem_address", MEM_ADDRESS, 0);
        check("t4_rst_instruction", INSTRUCTION, 0);
        PC = 32'h000;
        repeat (2) @(posedge CLK);
        fetch("t4_valid_cleared", 32'h000, 32'hCAFE_0000, 7, 0, 0);
        fetch("t4_line3_cleared", 32'h034, 32'hCAFE_0301, 7, 3, 3);

        fetch("t6_pc_switch", 32'h010, 32'hCAFE_0200, 14, 1, 2, 3, 32'h020);
        fetch("t6_line1_filled", 32'h014, 32'hCAFE_0101, 0, -1, -1);
        fetch("t6_line2_hit", 32'h02C, 32'hCAFE_0203, 0, -1, -1);
        fetch("t6_line0_kept", 32'h008, 32'hCAFE_0002, 0, -1, -1);

        #1;
        req = 1'b0;
        repeat (2) @(posedge CLK);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
